// File: rtl/cu_sequencer_pkg.sv
// Shared types for the control-unit sequencer: state and trap-cause encodings,
// opcode constants and the legal-opcode check also used by the opcode decoder.
package cu_sequencer_pkg;

    typedef enum logic [2:0] {
        StReset     = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExec      = 3'd3,
        StMem       = 3'd4,
        StWriteback = 3'd5,
        StTrap      = 3'd6
    } cu_state_t;

    typedef enum logic [1:0] {
        CauseNone        = 2'd0,
        CauseIllegal     = 2'd1,
        CauseIbusTimeout = 2'd2,
        CauseDbusTimeout = 2'd3
    } trap_cause_t;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        logic legal;
        case (op)
            OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/cu_sequencer_wait_timer.sv
// Bus wait-cycle counter shared by FETCH and MEM; expired flags the last
// permitted wait cycle. TIMEOUT_CYCLES of 0 disables expiry.
module cu_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] LAST =
        (TIMEOUT_CYCLES > 0) ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [WAIT_W-1:0] count_d, count_q;

    // Saturate at LAST so a disabled or abandoned count never wraps.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != LAST)) begin
            count_d = count_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count_q == LAST);

endmodule

// File: rtl/cu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/writeback over req/ack
// buses with timeout and illegal-opcode traps. CU_PERF_COUNTERS_EN adds perf counters.
module cu_sequencer
    import cu_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        stall,
    output logic        ibus_req,
    input  logic        ibus_ack,
    output logic        dbus_req,
    output logic        dbus_we,
    input  logic        dbus_ack,
    input  logic        trap_ack,
    output logic        load_ir,
    output logic        en_pc_counter,
    output logic        write_back_stage,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
`ifdef CU_PERF_COUNTERS_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    cu_state_t   state_d, state_q;
    trap_cause_t cause_d, cause_q;
    logic        wait_clear, wait_count_en, wait_expired;

    cu_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (wait_clear),
        .count_en(wait_count_en),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StReset;
            cause_q <= CauseNone;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Next state; an ack in the expiring cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                if (ibus_ack) begin
                    state_d = StDecode;
                end else if (wait_expired) begin
                    state_d = StTrap;
                    cause_d = CauseIbusTimeout;
                end
            end
            StDecode: begin
                if (!stall) begin
                    if (is_legal_opcode(opcode)) begin
                        state_d = StExec;
                    end else begin
                        state_d = StTrap;
                        cause_d = CauseIllegal;
                    end
                end
            end
            StExec: begin
                if (!stall) begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = StMem;
                        OP_BRANCH:         state_d = StFetch;
                        default:           state_d = StWriteback;
                    endcase
                end
            end
            StMem: begin
                if (dbus_ack) begin
                    state_d = (opcode == OP_STORE) ? StFetch : StWriteback;
                end else if (wait_expired) begin
                    state_d = StTrap;
                    cause_d = CauseDbusTimeout;
                end
            end
            StWriteback: begin
                if (!stall) begin
                    state_d = StFetch;
                end
            end
            StTrap: begin
                if (trap_ack) begin
                    state_d = StFetch;
                    cause_d = CauseNone;
                end
            end
            default: begin
                state_d = StReset;
                cause_d = CauseNone;
            end
        endcase
    end

    always_comb begin
        wait_clear    = (state_d != state_q) && ((state_d == StFetch) || (state_d == StMem));
        wait_count_en = ((state_q == StFetch) && !ibus_ack) || ((state_q == StMem) && !dbus_ack);
    end

    always_comb begin
        ibus_req         = (state_q == StFetch);
        load_ir          = (state_q == StFetch) && ibus_ack;
        dbus_req         = (state_q == StMem);
        dbus_we          = (state_q == StMem) && (opcode == OP_STORE);
        en_pc_counter    = (state_q == StExec) && !stall;
        write_back_stage = (state_q == StWriteback) && !stall;
        trap             = (state_q == StTrap);
        trap_cause       = cause_q;
        state            = state_q;
    end

`ifdef CU_PERF_COUNTERS_EN
    logic [31:0] cycle_cnt_d, cycle_cnt_q, instret_cnt_d, instret_cnt_q;

    // Retirement is any return to FETCH except the trap exit.
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != StReset) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if ((state_d == StFetch) && ((state_q == StExec) || (state_q == StMem) ||
                                     (state_q == StWriteback))) begin
            instret_cnt_d = instret_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_cu_sequencer.sv
// Randomized bench for cu_sequencer: a plan of instructions is laid out cycle by
// cycle from the sequencing rules, expected events are queued, a monitor checks them.
module tb_cu_sequencer;

    localparam int MAXC = 6000;
    localparam int TO   = 16;

    localparam logic [6:0] T_ALU    = 7'b0110011;
    localparam logic [6:0] T_ALUI   = 7'b0010011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = '0;
    logic       stall = 1'b0, ibus_ack = 1'b0, dbus_ack = 1'b0, trap_ack = 1'b0;
    logic       ibus_req, dbus_req, dbus_we, load_ir, en_pc_counter, write_back_stage, trap;
    logic [1:0] trap_cause;
    logic [2:0] state;
`ifdef CU_PERF_COUNTERS_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    cu_sequencer #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .opcode          (opcode),
        .stall           (stall),
        .ibus_req        (ibus_req),
        .ibus_ack        (ibus_ack),
        .dbus_req        (dbus_req),
        .dbus_we         (dbus_we),
        .dbus_ack        (dbus_ack),
        .trap_ack        (trap_ack),
        .load_ir         (load_ir),
        .en_pc_counter   (en_pc_counter),
        .write_back_stage(write_back_stage),
        .trap            (trap),
        .trap_cause      (trap_cause),
        .state           (state)
`ifdef CU_PERF_COUNTERS_EN
        ,
        .cycle_cnt       (cycle_cnt),
        .instret_cnt     (instret_cnt)
`endif
    );

    // ev = {load_ir, en_pc, wb, dbus handshake, dbus_we, trap entry, trap_cause}
    typedef struct {
        int         cyc;
        logic [7:0] ev;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] mon_act;
    logic       p_ibus[MAXC];
    logic       p_dbus[MAXC];
    logic       p_stall[MAXC];
    logic       p_tack[MAXC];
    logic [6:0] p_op[MAXC];
    logic [6:0] legal_ops[9];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         cend = 0;
    int         n_ret = 0;
    bit         mon_en = 1'b0;
    logic       trap_prev = 1'b0;

    function automatic bit is_legal(input logic [6:0] op);
        for (int i = 0; i < 9; i++) begin
            if (legal_ops[i] == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void push(input int c, input logic [5:0] flags, input logic [1:0] cs);
        exp_t e;
        e.cyc = c;
        e.ev  = {flags, cs};
        exp_q.push_back(e);
    endfunction

    function automatic int pick_wait();
        int r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 3);
        if (r < 8) return TO - 1;
        return TO;
    endfunction

    function automatic int pick_stall();
        int r = $urandom_range(0, 9);
        if (r < 6) return 0;
        if (r < 9) return $urandom_range(1, 2);
        return 5;
    endfunction

    function automatic void set_stall(input int c, input int s);
        for (int i = 0; i < s; i++) p_stall[c + i] = 1'b1;
        p_stall[c + s] = 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Lay out stimulus and expected events for a sequence of instructions.
    task automatic plan();
        int t = 1;
        int ninstr = 0;
        for (int c = 0; c < MAXC; c++) begin
            p_ibus[c]  = 1'($urandom_range(0, 1));
            p_dbus[c]  = 1'($urandom_range(0, 1));
            p_stall[c] = 1'($urandom_range(0, 1));
            p_tack[c]  = 1'b0;
            p_op[c]    = '0;
        end
        p_ibus[0] = 1'b0;
        p_dbus[0] = 1'b0;
        p_stall[0] = 1'b0;
        while (t < MAXC - 120 && ninstr < 120) begin
            logic [6:0] op;
            int wi, wm, sd, se, sw, d, e, m, w, x, k;
            int r = $urandom_range(0, 9);
            bit trapped = 1'b0;
            logic [1:0] cause = 2'd0;
            if (r < 9) begin
                op = legal_ops[r];
            end else begin
                op = ($urandom_range(0, 1) == 1) ? 7'd0 : 7'($urandom_range(0, 127));
                while (is_legal(op)) op = 7'($urandom_range(0, 127));
            end
            for (int c = t; c < t + 100; c++) p_op[c] = op;
            ninstr++;
            wi = pick_wait();
            for (int c = t; c < t + wi && c < t + TO; c++) p_ibus[c] = 1'b0;
            if (wi >= TO) begin
                trapped = 1'b1;
                x = t + TO;
                cause = 2'd2;
            end else begin
                p_ibus[t + wi] = 1'b1;
                push(t + wi, 6'b100000, 2'd0);
                d = t + wi + 1;
                sd = pick_stall();
                set_stall(d, sd);
                if (!is_legal(op)) begin
                    trapped = 1'b1;
                    x = d + sd + 1;
                    cause = 2'd1;
                end else begin
                    e = d + sd + 1;
                    se = pick_stall();
                    set_stall(e, se);
                    push(e + se, 6'b010000, 2'd0);
                    w = -1;
                    if (op == T_BRANCH) begin
                        t = e + se + 1;
                    end else if (op == T_LOAD || op == T_STORE) begin
                        m = e + se + 1;
                        wm = pick_wait();
                        for (int c = m; c < m + wm && c < m + TO; c++) p_dbus[c] = 1'b0;
                        if (wm >= TO) begin
                            trapped = 1'b1;
                            x = m + TO;
                            cause = 2'd3;
                        end else begin
                            p_dbus[m + wm] = 1'b1;
                            push(m + wm, {4'b0001, (op == T_STORE), 1'b0}, 2'd0);
                            if (op == T_STORE) t = m + wm + 1;
                            else w = m + wm + 1;
                        end
                    end else begin
                        w = e + se + 1;
                    end
                    if (w >= 0) begin
                        sw = pick_stall();
                        set_stall(w, sw);
                        push(w + sw, 6'b001000, 2'd0);
                        t = w + sw + 1;
                    end
                    if (!trapped) n_ret++;
                end
            end
            if (trapped) begin
                push(x, 6'b000001, cause);
                k = $urandom_range(0, 3);
                for (int c = x; c < x + k; c++) p_tack[c] = 1'b0;
                p_tack[x + k] = 1'b1;
                t = x + k + 1;
            end
        end
        cend = t;
        p_ibus[cend] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_act = {load_ir, en_pc_counter, write_back_stage, dbus_req && dbus_ack, dbus_we,
                       trap && !trap_prev, trap_cause};
            if (load_ir || en_pc_counter || write_back_stage || (dbus_req && dbus_ack) ||
                (trap && !trap_prev)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: cycle %0d got %b required none", cyc, mon_act);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.ev !== mon_act) begin
                        n_fail++;
                        $display("FAIL event: got cycle %0d ev %b required cycle %0d ev %b",
                                 cyc, mon_act, mon_e.cyc, mon_e.ev);
                    end
                end
            end
        end
        trap_prev <= trap;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_ibus_req"}, 32'(ibus_req), 32'd0);
        chk({tag, "_dbus_req"}, 32'(dbus_req), 32'd0);
        chk({tag, "_dbus_we"}, 32'(dbus_we), 32'd0);
        chk({tag, "_load_ir"}, 32'(load_ir), 32'd0);
        chk({tag, "_en_pc"}, 32'(en_pc_counter), 32'd0);
        chk({tag, "_wb"}, 32'(write_back_stage), 32'd0);
        chk({tag, "_trap"}, 32'(trap), 32'd0);
        chk({tag, "_cause"}, 32'(trap_cause), 32'd0);
    endtask

    initial begin
        legal_ops = '{T_ALU, T_ALUI, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC};
        plan();
        ibus_ack = 1'b1;
        stall    = 1'b1;
        opcode   = T_STORE;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        ibus_ack = 1'b0;
        stall    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        mon_en = 1'b1;
        #1;
        chk("cycle0_state", 32'(state), 32'd0);
        while (cyc < cend) begin
            @(posedge clk);
            cyc++;
            #1;
            ibus_ack = p_ibus[cyc];
            dbus_ack = p_dbus[cyc];
            stall    = p_stall[cyc];
            trap_ack = p_tack[cyc];
            opcode   = p_op[cyc];
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("end_state_fetch", 32'(state), 32'd1);
        chk("end_ibus_req", 32'(ibus_req), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef CU_PERF_COUNTERS_EN
        chk("cycle_cnt", cycle_cnt, 32'(cend - 1));
        chk("instret_cnt", instret_cnt, 32'(n_ret));
`endif

        // Reset asserted in the middle of a LOAD's MEM phase.
        rst = 1'b0;
        ibus_ack = 1'b0;
        dbus_ack = 1'b0;
        stall = 1'b0;
        trap_ack = 1'b0;
        opcode = T_LOAD;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 ibus_ack = 1'b1;
        @(posedge clk);
        #1 ibus_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_mem_state", 32'(state), 32'd4);
        chk("mid_mem_dbus_req", 32'(dbus_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
